satd_row_scheduler: RTL and testbench
=====================================

# satd_row_scheduler

Sequencing controller for the SATD difference datapath. Accepts one "block start" request per 8x8-row block, walks the row index across the block (default 16 rows of 64-bit ORG/CUR slices), drives the row-select and enable of the one-cycle difference stage, and tags each difference result with a valid/ready handshake, row number and last flag. It replaces free-running counter control so downstream Hadamard/accumulate stages can apply back-pressure.

## Interface
Parameters:
- ROWS, 16, rows per block; legal range 2..2**ROW_W.
- ROW_W, 4, row index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request to process one block.
- start_ready  out  1  high only in IDLE; a start is accepted when start_valid & start_ready.
- row_sel  out  ROW_W  slice select for ORG/CUR mux (row issued this cycle).
- diff_en  out  1  load enable for difference register.
- diff_clr  out  1  one-cycle clear of difference register, in the start-accept cycle.
- out_valid  out  1  difference outputs hold a valid row.
- out_ready  in  1  downstream accepts the row.
- out_row  out  ROW_W  row index of current difference result.
- out_last  out  1  out_valid row is row ROWS-1.
- done  out  1  one-cycle pulse after the last row is accepted.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start_ready=1. Start accepted -> diff_clr=1, row counter=0, next state RUN.
- Pipeline advance: adv = !out_valid | out_ready.
- RUN: when adv, diff_en=1, row_sel=counter, counter+1; issuing row ROWS-1 -> DRAIN. When !adv: diff_en=0, counter and row_sel hold.
- Result tag register: loads {valid=1, row=row_sel, last=(row_sel==ROWS-1)} when diff_en; clears valid when out_valid & out_ready and no new issue.
- DRAIN: no issue; on handshake of out_last row -> IDLE, done=1 next cycle.
- Counter compares against ROWS-1 (not power-of-two wrap); counter never exceeds ROWS-1; returns to 0 only on start accept.
- start_valid outside IDLE is ignored (not queued).
- Reset: state IDLE, counter 0, out_valid 0, out_row 0, out_last 0, done 0, diff_en 0, diff_clr 0, busy 0, row_sel 0; start_ready 1 in first post-reset cycle. rst mid-block discards in-flight row, no done.

## Timing
- Start accepted in cycle T: T+1 first issue (row 0), T+2 out_valid with out_row=0.
- No stall: rows issued T+1..T+ROWS, out_valid T+2..T+ROWS+1, out_last at T+ROWS+1, done and start_ready at T+ROWS+2.
- Back-to-back start accepted in done cycle; minimum block period ROWS+2 cycles.
- out_ready low with out_valid high: out_valid/out_row/out_last stable, diff_en=0, row_sel held, until handshake.
- out_ready only affects cycles where out_valid=1 (no ready-before-valid dependency).

## Configuration
- SATD_SCHED_ABORT_EN defined: adds input abort (1 bit) and output aborted (1 bit). abort high in RUN or DRAIN -> next cycle IDLE, out_valid 0, diff_en 0, no done, aborted pulses 1 cycle; abort in IDLE ignored; abort wins over simultaneous last handshake (no done).
- Not defined: ports absent, block always runs to completion.

## Structure
- Shared package satd_pkg: state enum (IDLE/RUN/DRAIN), default ROWS/ROW_W constants, row-tag struct {valid,row,last}.
- One natural sub-module: satd_row_counter (enable, load-zero, terminal-count flag at ROWS-1). FSM and tag register stay in the top.

## Test plan
- Reset then single start, out_ready tied high -> out_row 0..15 on 16 consecutive cycles from T+2, out_last only with row 15, done at T+18.
- out_ready low for 3 cycles while out_row=5 -> out_row stays 5, diff_en=0, row_sel held at 6, no row skipped or duplicated.
- start_valid held high continuously -> starts accepted at T and T+18, done pulses at T+18 and T+36, start_ready low in between.
- rst asserted at row 7 -> next cycle all outputs at reset values, no done; new start then yields rows 0..15.
- ROWS=5 instance -> rows 0..4, out_last at row 4, done at T+7, counter never shows 5..15.
- With SATD_SCHED_ABORT_EN, abort at row 3 -> aborted pulse, out_valid 0 next cycle, no done; without macro, same stimulus runs all 16 rows.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared types and defaults for the SATD row scheduler.
package satd_pkg;

  localparam int unsigned ROWS_DEF  = 16;
  localparam int unsigned ROW_W_DEF = 4;
  // Tag row field is sized for the widest supported row index.
  localparam int unsigned TAG_ROW_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_ROW_W-1:0] row;
    logic                 last;
  } row_tag_t;

endpackage

// File: rtl/satd_row_counter.sv
// Row index counter: clears on load, advances on enable, saturates at ROWS-1.
module satd_row_counter
  import satd_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_zero_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] count_q;
  logic [ROW_W-1:0] count_d;

  assign tc_o    = (count_q == LAST_ROW);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (load_zero_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/satd_row_scheduler.sv
// Row sequencer for the SATD difference stage with a valid/ready result tag.
// Optional abort input/aborted pulse enabled by defining SATD_SCHED_ABORT_EN.
module satd_row_scheduler
  import satd_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  output logic [ROW_W-1:0] row_sel,
  output logic             diff_en,
  output logic             diff_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             done,
  output logic             busy
`ifdef SATD_SCHED_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  state_e   state_q;
  state_e   state_d;
  row_tag_t tag_q;
  row_tag_t tag_d;
  logic     done_q;
  logic     done_d;

  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic [ROW_W-1:0] cnt;

  logic adv;
  logic last_hs;
  logic abort_w;
  logic abort_act;

`ifdef SATD_SCHED_ABORT_EN
  logic aborted_q;
  assign abort_w = abort;
  assign aborted = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  assign adv       = !tag_q.valid || out_ready;
  assign last_hs   = tag_q.valid && tag_q.last && out_ready;
  assign abort_act = abort_w && (state_q != ST_IDLE);

  satd_row_counter #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_row_counter (
    .clk         (clk),
    .rst         (rst),
    .load_zero_i (cnt_load),
    .en_i        (cnt_en),
    .count_o     (cnt),
    .tc_o        (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_act)          state_d = ST_IDLE;
        else if (adv && cnt_tc) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_act || last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue control is combinational so a stall blocks the issue in the same cycle.
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    diff_clr    = 1'b0;
    diff_en     = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        diff_clr    = start_valid;
        cnt_load    = start_valid;
      end
      ST_RUN: begin
        diff_en = adv && !abort_act;
        cnt_en  = adv && !abort_act;
      end
      ST_DRAIN: begin
        done_d = last_hs && !abort_act;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign row_sel = cnt;

  always_comb begin
    tag_d = tag_q;
    if (abort_act) begin
      tag_d.valid = 1'b0;
      tag_d.last  = 1'b0;
    end else if (diff_en) begin
      tag_d.valid = 1'b1;
      tag_d.row   = TAG_ROW_W'(cnt);
      tag_d.last  = cnt_tc;
    end else if (tag_q.valid && out_ready) begin
      tag_d.valid = 1'b0;
      tag_d.last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= '0;
      done_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      done_q <= done_d;
    end
  end

`ifdef SATD_SCHED_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_act;
    end
  end
`endif

  assign out_valid = tag_q.valid;
  assign out_row   = ROW_W'(tag_q.row);
  assign out_last  = tag_q.last;
  assign done      = done_q;

endmodule

// File: tb/tb_satd_row_scheduler.sv
// Directed self-checking bench for satd_row_scheduler (16-row and 5-row instances).
module tb_satd_row_scheduler;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] row_sel;
  logic       diff_en;
  logic       diff_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_row;
  logic       out_last;
  logic       done;
  logic       busy;

  logic       s_start_valid;
  logic       s_start_ready;
  logic [3:0] s_row_sel;
  logic       s_diff_en;
  logic       s_diff_clr;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [3:0] s_out_row;
  logic       s_out_last;
  logic       s_done;
  logic       s_busy;

`ifdef SATD_SCHED_ABORT_EN
  logic abort;
  logic aborted;
  logic s_abort;
  logic s_aborted;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  satd_row_scheduler #(.ROWS(16), .ROW_W(4)) u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .row_sel(row_sel), .diff_en(diff_en), .diff_clr(diff_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last), .done(done), .busy(busy)
`ifdef SATD_SCHED_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  satd_row_scheduler #(.ROWS(5), .ROW_W(4)) u_small (
    .clk(clk), .rst(rst), .start_valid(s_start_valid), .start_ready(s_start_ready),
    .row_sel(s_row_sel), .diff_en(s_diff_en), .diff_clr(s_diff_clr), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_row(s_out_row), .out_last(s_out_last), .done(s_done),
    .busy(s_busy)
`ifdef SATD_SCHED_ABORT_EN
    , .abort(s_abort), .aborted(s_aborted)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".start_ready"}, start_ready, 1);
    chk({tag, ".busy"},        busy,        0);
    chk({tag, ".out_valid"},   out_valid,   0);
    chk({tag, ".out_row"},     out_row,     0);
    chk({tag, ".out_last"},    out_last,    0);
    chk({tag, ".done"},        done,        0);
    chk({tag, ".diff_en"},     diff_en,     0);
    chk({tag, ".diff_clr"},    diff_clr,    0);
    chk({tag, ".row_sel"},     row_sel,     0);
  endtask

  // One start with out_ready high, cycle-exact checks from T+1 to T+18.
  task automatic run_nominal(input string tag);
    step();
    start_valid = 1'b1;
    #1;
    chk({tag, ".accept_clr"},   diff_clr,    1);
    chk({tag, ".accept_ready"}, start_ready, 1);
    for (int k = 1; k <= 18; k++) begin
      step();
      start_valid = 1'b0;
      #1;
      chk({tag, ".diff_en"}, diff_en, (k <= 16) ? 1 : 0);
      if (k <= 16) chk({tag, ".row_sel"}, row_sel, k - 1);
      chk({tag, ".out_valid"}, out_valid, (k >= 2 && k <= 17) ? 1 : 0);
      if (k >= 2 && k <= 17) chk({tag, ".out_row"}, out_row, k - 2);
      chk({tag, ".out_last"},    out_last,    (k == 17) ? 1 : 0);
      chk({tag, ".done"},        done,        (k == 18) ? 1 : 0);
      chk({tag, ".start_ready"}, start_ready, (k == 18) ? 1 : 0);
      chk({tag, ".busy"},        busy,        (k <= 17) ? 1 : 0);
    end
  endtask

  initial begin
    int unsigned exp_row;
    bit          got_done;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start_valid = 1'b0;
    out_ready = 1'b1;
    s_start_valid = 1'b0;
    s_out_ready = 1'b1;
`ifdef SATD_SCHED_ABORT_EN
    abort = 1'b0;
    s_abort = 1'b0;
`endif

    step();
    step();
    rst = 1'b0;
    #1;
    check_reset("reset");

    run_nominal("nominal");

    // Three-cycle stall while row 5 is presented.
    step();
    start_valid = 1'b1;
    #1;
    exp_row = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 30 && !got_done; k++) begin
      step();
      start_valid = 1'b0;
      out_ready = !(k >= 7 && k <= 9);
      #1;
      if (k >= 7 && k <= 9) begin
        chk("stall.valid",   out_valid, 1);
        chk("stall.row",     out_row,   5);
        chk("stall.diff_en", diff_en,   0);
        chk("stall.row_sel", row_sel,   6);
      end
      if (out_valid && out_ready) begin
        chk("stall.seq",  out_row,  exp_row);
        chk("stall.last", out_last, (exp_row == 15) ? 1 : 0);
        exp_row++;
      end
      if (done) begin
        chk("stall.done_cycle", k, 21);
        got_done = 1'b1;
      end
    end
    out_ready = 1'b1;
    chk("stall.rows_seen", exp_row, 16);
    chk("stall.got_done", got_done, 1);

    // start_valid held high: accepts every 18 cycles.
    for (int k = 0; k <= 36; k++) begin
      step();
      start_valid = 1'b1;
      #1;
      chk("hold.start_ready", start_ready, (k % 18 == 0) ? 1 : 0);
      chk("hold.diff_clr",    diff_clr,    (k % 18 == 0) ? 1 : 0);
      chk("hold.done",        done,        (k == 18 || k == 36) ? 1 : 0);
    end
    got_done = 1'b0;
    for (int j = 1; j <= 30 && !got_done; j++) begin
      step();
      start_valid = 1'b0;
      #1;
      if (done) begin
        chk("hold.done3_cycle", j, 18);
        got_done = 1'b1;
      end
    end
    chk("hold.got_done3", got_done, 1);

    // Reset while row 7 is presented.
    step();
    start_valid = 1'b1;
    #1;
    for (int k = 1; k <= 9; k++) begin
      step();
      start_valid = 1'b0;
      #1;
    end
    chk("rstmid.row_before", out_row, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset("rstmid");
    step();
    chk("rstmid.no_done", done, 0);
    run_nominal("rerun");

    // Five-row instance.
    step();
    s_start_valid = 1'b1;
    #1;
    chk("small.accept_clr", s_diff_clr, 1);
    for (int k = 1; k <= 9; k++) begin
      step();
      s_start_valid = 1'b0;
      #1;
      chk("small.row_sel_max", (s_row_sel <= 4'd4) ? 1 : 0, 1);
      chk("small.out_valid", s_out_valid, (k >= 2 && k <= 6) ? 1 : 0);
      if (k >= 2 && k <= 6) chk("small.out_row", s_out_row, k - 2);
      chk("small.out_last", s_out_last, (k == 6) ? 1 : 0);
      chk("small.done",     s_done,     (k == 7) ? 1 : 0);
    end

    // Abort request while row 3 is presented.
    step();
    start_valid = 1'b1;
    #1;
    for (int k = 1; k <= 5; k++) begin
      step();
      start_valid = 1'b0;
      #1;
    end
    chk("abort.row_before", out_row, 3);
`ifdef SATD_SCHED_ABORT_EN
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    chk("abort.aborted",     aborted,     1);
    chk("abort.out_valid",   out_valid,   0);
    chk("abort.done",        done,        0);
    chk("abort.busy",        busy,        0);
    chk("abort.diff_en",     diff_en,     0);
    chk("abort.start_ready", start_ready, 1);
    step();
    chk("abort.pulse_end", aborted, 0);
    chk("abort.no_done",   done,    0);
`else
    for (int k = 6; k <= 18; k++) begin
      step();
      #1;
      if (k <= 17) begin
        chk("noabort.out_valid", out_valid, 1);
        chk("noabort.out_row",   out_row,   k - 2);
      end
      chk("noabort.done", done, (k == 18) ? 1 : 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
